// File: rtl/rsa_mont_arbiter.sv
// rsa_mont_pkg / rsa_mont_arbiter
//
// Shares one RSAMont modular-exponentiation engine among N_REQ requesters.
// A round-robin pick in IDLE registers the winner's operands. The arbiter
// issues them to the engine, captures the result and returns it to the
// requester that was granted. Only one job is in flight at a time.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req_valid/ready     per-requester request handshake
//   req_in              per-requester operands (base, msg, key, modulus)
//   rsp_valid/ready     per-requester response handshake
//   rsp_out, rsp_id     shared result bus and the index of its owner
//   eng_i_*             operand handshake towards the engine
//   eng_o_*             result handshake from the engine
//   busy                high whenever the arbiter is not idle
//   last_latency        engine issue-to-result cycles of the last job

package rsa_mont_pkg;
  localparam int KW = 32;

  typedef struct packed {
    logic [KW-1:0] base;
    logic [KW-1:0] msg;
    logic [KW-1:0] key;
    logic [KW-1:0] modulus;
  } rsa_mont_mod_in_t;

  typedef struct packed {
    logic [KW-1:0] out;
  } rsa_mont_mod_out_t;
endpackage

// state  | meaning
// S_IDLE | waiting for a request; round-robin winner gets req_ready
// S_ISSUE| registered job offered to the engine
// S_WAIT | engine busy; waiting for its result
// S_RESP | result presented to the granted requester
module rsa_mont_arbiter
  import rsa_mont_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int GW    = $clog2(N_REQ),
  parameter int CW    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req_valid,
  output logic [N_REQ-1:0]    req_ready,
  input  rsa_mont_mod_in_t    req_in [N_REQ],
  output logic [N_REQ-1:0]    rsp_valid,
  input  logic [N_REQ-1:0]    rsp_ready,
  output rsa_mont_mod_out_t   rsp_out,
  output logic [GW-1:0]       rsp_id,
  output logic                eng_i_valid,
  input  logic                eng_i_ready,
  output rsa_mont_mod_in_t    eng_i_in,
  input  logic                eng_o_valid,
  output logic                eng_o_ready,
  input  rsa_mont_mod_out_t   eng_o_out,
  output logic                busy,
  output logic [CW-1:0]       last_latency
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t            state_q, state_d;
  logic [GW-1:0]     last_grant_q, last_grant_d;
  logic [GW-1:0]     grant_q, grant_d;
  rsa_mont_mod_in_t  job_q, job_d;
  rsa_mont_mod_out_t result_q, result_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CW-1:0]     last_latency_q, last_latency_d;

  logic              win_found;
  logic [GW-1:0]     win_idx;
  logic [GW-1:0]     cand;
  logic [CW-1:0]     cnt_sat;

  // Search starts just after the last served requester and wraps, so a
  // requester that keeps req_valid high waits for at most N_REQ-1 jobs.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = GW'((int'(last_grant_q) + k) % N_REQ);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign cnt_sat = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);

  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    grant_d        = grant_q;
    job_d          = job_q;
    result_d       = result_q;
    cnt_d          = cnt_q;
    last_latency_d = last_latency_q;
    req_ready      = '0;
    rsp_valid      = '0;
    eng_i_valid    = 1'b0;
    eng_o_ready    = 1'b0;

    case (state_q)
      S_IDLE: begin
        // rst_n gate keeps req_ready low while reset holds the FSM in IDLE.
        if (rst_n && win_found) begin
          req_ready[win_idx] = 1'b1;
          job_d              = req_in[win_idx];
          grant_d            = win_idx;
          cnt_d              = '0;
          state_d            = S_ISSUE;
        end
      end
      S_ISSUE: begin
        eng_i_valid = 1'b1;
        cnt_d       = cnt_sat;
        if (eng_i_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        eng_o_ready = 1'b1;
        cnt_d       = cnt_sat;
        if (eng_o_valid) begin
          result_d       = eng_o_out;
          last_latency_d = cnt_sat;
          state_d        = S_RESP;
        end
      end
      S_RESP: begin
        rsp_valid[grant_q] = 1'b1;
        if (rsp_ready[grant_q]) begin
          last_grant_d = grant_q;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      last_grant_q   <= GW'(N_REQ - 1);
      grant_q        <= '0;
      job_q          <= '0;
      result_q       <= '0;
      cnt_q          <= '0;
      last_latency_q <= '0;
    end else begin
      state_q        <= state_d;
      last_grant_q   <= last_grant_d;
      grant_q        <= grant_d;
      job_q          <= job_d;
      result_q       <= result_d;
      cnt_q          <= cnt_d;
      last_latency_q <= last_latency_d;
    end
  end

  assign rsp_out      = result_q;
  assign rsp_id       = grant_q;
  assign eng_i_in     = job_q;
  assign busy         = (state_q != S_IDLE);
  assign last_latency = last_latency_q;

endmodule

// File: tb/tb_rsa_mont_arbiter.sv
// Bench for rsa_mont_arbiter with three requesters and an engine stub that
// raises eng_i_ready one cycle (plus an optional hold) after eng_i_valid and
// returns msg^key in the fifth cycle after accepting.
module tb_rsa_mont_arbiter;
  import rsa_mont_pkg::*;

  localparam int N  = 3;
  localparam int GW = 2;
  localparam int CW = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N-1:0]      req_valid = '0;
  logic [N-1:0]      req_ready;
  rsa_mont_mod_in_t  req_in [N];
  logic [N-1:0]      rsp_valid;
  logic [N-1:0]      rsp_ready = '0;
  rsa_mont_mod_out_t rsp_out;
  logic [GW-1:0]     rsp_id;
  logic              eng_i_valid;
  logic              eng_i_ready;
  rsa_mont_mod_in_t  eng_i_in;
  logic              eng_o_valid;
  logic              eng_o_ready;
  rsa_mont_mod_out_t eng_o_out;
  logic              busy;
  logic [CW-1:0]     last_latency;

  rsa_mont_arbiter #(.N_REQ(N), .GW(GW), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_in(req_in),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_out(rsp_out), .rsp_id(rsp_id),
    .eng_i_valid(eng_i_valid), .eng_i_ready(eng_i_ready), .eng_i_in(eng_i_in),
    .eng_o_valid(eng_o_valid), .eng_o_ready(eng_o_ready), .eng_o_out(eng_o_out),
    .busy(busy), .last_latency(last_latency)
  );

  always #5 clk = ~clk;

  // engine stub
  int                hold_extra = 0;
  int                vcnt;
  int                cd;
  logic              stub_o_valid;
  logic              stray_o_valid = 1'b0;
  rsa_mont_mod_out_t stub_res;

  assign eng_o_valid = stub_o_valid | stray_o_valid;
  assign eng_o_out   = stub_res;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eng_i_ready  <= 1'b0;
      stub_o_valid <= 1'b0;
      vcnt         <= 0;
      cd           <= 0;
      stub_res     <= '0;
    end else begin
      if (eng_i_valid && eng_i_ready) begin
        eng_i_ready  <= 1'b0;
        vcnt         <= 0;
        cd           <= 4;
        stub_res.out <= eng_i_in.msg ^ eng_i_in.key;
      end else if (eng_i_valid) begin
        eng_i_ready <= (vcnt >= hold_extra);
        vcnt        <= vcnt + 1;
      end
      if (cd > 0) begin
        cd <= cd - 1;
        if (cd == 1) stub_o_valid <= 1'b1;
      end
      if (stub_o_valid && eng_o_ready) stub_o_valid <= 1'b0;
    end
  end

  // checking and reference model
  int passed = 0;
  int total  = 0;
  int last_g = N - 1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int rr_pick(input logic [N-1:0] m, input int lg);
    for (int k = 1; k <= N; k++)
      if (m[(lg + k) % N]) return (lg + k) % N;
    return 0;
  endfunction

  function automatic rsa_mont_mod_in_t rand_op();
    rsa_mont_mod_in_t o;
    o.base    = $urandom;
    o.msg     = $urandom;
    o.key     = $urandom;
    o.modulus = $urandom;
    return o;
  endfunction

  // Called at a negedge; asserts reset, checks the quiescent outputs and
  // releases reset on the next negedge.
  task automatic reset_now(input string tag);
    rst_n = 1'b0;
    req_valid = '0;
    rsp_ready = '0;
    stray_o_valid = 1'b0;
    #1;
    chk({tag, "_busy"},        128'(busy),         128'(0));
    chk({tag, "_req_ready"},   128'(req_ready),    128'(0));
    chk({tag, "_rsp_valid"},   128'(rsp_valid),    128'(0));
    chk({tag, "_eng_i_valid"}, 128'(eng_i_valid),  128'(0));
    chk({tag, "_eng_o_ready"}, 128'(eng_o_ready),  128'(0));
    chk({tag, "_rsp_id"},      128'(rsp_id),       128'(0));
    chk({tag, "_last_lat"},    128'(last_latency), 128'(0));
    chk({tag, "_rsp_out"},     128'(rsp_out),      128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    last_g = N - 1;
  endtask

  // One complete job, called at a negedge with the arbiter in IDLE.
  task automatic do_job(input logic [N-1:0] mask, input int hold, input int bp);
    int                w;
    int                n;
    logic [N-1:0]      oh;
    rsa_mont_mod_in_t  op;
    rsa_mont_mod_out_t held;
    w  = rr_pick(mask, last_g);
    oh = N'(1) << w;
    hold_extra = hold;
    req_valid = mask;
    #1;
    chk("grant_req_ready", 128'(req_ready), 128'(oh));
    op = req_in[w];
    @(negedge clk);
    req_in[w] = rand_op();
    #1;
    chk("busy_after_accept", 128'(busy), 128'(1));
    chk("no_req_ready_busy", 128'(req_ready), 128'(0));
    chk("eng_i_in_first", 128'(eng_i_in), 128'(op));
    n = 0;
    while (!(eng_i_valid && eng_i_ready) && n < 100) begin
      @(negedge clk); #1; n++;
    end
    chk("issue_in_time", 128'(n < 100), 128'(1));
    chk("eng_i_in_at_accept", 128'(eng_i_in), 128'(op));
    n = 0;
    while (rsp_valid == '0 && n < 100) begin
      @(negedge clk); #1; n++;
    end
    chk("rsp_in_time", 128'(n < 100), 128'(1));
    chk("rsp_valid", 128'(rsp_valid), 128'(oh));
    chk("rsp_id", 128'(rsp_id), 128'(w));
    chk("rsp_out", 128'(rsp_out.out), 128'(op.msg ^ op.key));
    chk("last_latency", 128'(last_latency), 128'(7 + hold));
    held = rsp_out;
    // non-granted requesters raising rsp_ready must not end the response
    rsp_ready = mask & ~oh;
    if (bp > 0) begin
      repeat (bp) @(negedge clk);
      #1;
      chk("bp_rsp_valid", 128'(rsp_valid), 128'(oh));
      chk("bp_rsp_out", 128'(rsp_out), 128'(held));
      chk("bp_req_ready", 128'(req_ready), 128'(0));
      chk("bp_busy", 128'(busy), 128'(1));
    end
    rsp_ready = oh;
    @(negedge clk);
    rsp_ready = '0;
    last_g = w;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    for (int i = 0; i < N; i++) req_in[i] = rand_op();
    req_in[0].msg = 32'h0000_1234;
    req_in[0].key = 32'h0000_00FF;
    @(negedge clk);
    reset_now("rst0");

    // single job from requester 0
    do_job(3'b001, 0, 0);
    chk("single_rsp_out", 128'(rsp_out.out), 128'(32'h0000_12CB));
    chk("single_latency", 128'(last_latency), 128'(7));

    // contention after reset, with response backpressure on requester 1
    req_valid = '0;
    reset_now("rst1");
    do_job(3'b011, 0, 0);
    do_job(3'b011, 0, 20);
    do_job(3'b011, 0, 0);

    // round-robin wrap
    req_valid = '0;
    reset_now("rst2");
    for (int j = 0; j < 6; j++) begin
      chk("rr_order", 128'(rr_pick(3'b111, last_g)), 128'(j % 3));
      do_job(3'b111, 0, 0);
    end
    do_job(3'b100, 0, 0);
    chk("after_2_is_0", 128'(rr_pick(3'b111, last_g)), 128'(0));
    do_job(3'b111, 0, 0);

    // engine input backpressure
    do_job(3'b001, 10, 0);
    chk("eng_bp_latency", 128'(last_latency), 128'(17));

    // randomized traffic
    for (int j = 0; j < 20; j++)
      do_job(3'($urandom_range(1, 7)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));

    // reset while the engine is busy
    do_job(3'b001, 0, 0);
    hold_extra = 0;
    req_valid = 3'b010;
    #1;
    chk("mid_grant", 128'(req_ready), 128'(3'b010));
    n = 0;
    while (!eng_o_ready && n < 100) begin
      @(negedge clk); #1; n++;
    end
    chk("reached_wait", 128'(eng_o_ready), 128'(1));
    reset_now("rst_mid");
    stray_o_valid = 1'b1;
    @(negedge clk);
    stray_o_valid = 1'b0;
    #1;
    chk("stray_busy", 128'(busy), 128'(0));
    chk("stray_rsp_valid", 128'(rsp_valid), 128'(0));
    chk("stray_last_lat", 128'(last_latency), 128'(0));
    chk("post_rst_pick", 128'(rr_pick(3'b111, last_g)), 128'(0));
    do_job(3'b111, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
